// File: rtl/midori_mask_pkg.sv
// Shared constants and FSM state type for the masked Midori affine datapath.
package midori_mask_pkg;
    localparam int STATE_W  = 64;
    localparam int NIBBLE_W = 4;
    localparam int SHARES   = 3;

    localparam logic [NIBBLE_W-1:0] AFFINE_CONST     = 4'b1001;
    localparam logic [NIBBLE_W-1:0] AFFINE_INV_CONST = 4'b0110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/midori_affine_inv_serial_if.sv
// Three-share request/result bus with valid/ready handshakes on both sides.
interface midori_affine_inv_serial_if;
    import midori_mask_pkg::*;
    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] s1, s2, s3;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] o1, o2, o3;

    modport master (output in_valid, s1, s2, s3, out_ready,
                    input  in_ready, out_valid, o1, o2, o3);
    modport slave  (input  in_valid, s1, s2, s3, out_ready,
                    output in_ready, out_valid, o1, o2, o3);
endinterface

// File: rtl/affine_inv_nibble.sv
// Inverse output-affine map on one nibble of one share; cen adds the share-1 constant.
module affine_inv_nibble
    import midori_mask_pkg::*;
(
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cen,
    output logic [NIBBLE_W-1:0] x
);
    logic [NIBBLE_W-1:0] lin;

    assign lin = {y[2], y[3] ^ y[2] ^ y[1], y[0], y[2] ^ y[1]};
    assign x   = lin ^ (cen ? AFFINE_INV_CONST : '0);
endmodule

// File: rtl/midori_affine_inv_serial.sv
// Serial 3-share inverse affine layer, LANES nibbles per step, rotate-right datapath.
// Optional AFFINE_INV_ZEROIZE_EN: wipe shares on delivery and gate outputs outside DONE.
module midori_affine_inv_serial
    import midori_mask_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    midori_affine_inv_serial_if.slave   bus
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W  = NIBBLE_W * LANES;

    state_t                               state, state_nx;
    logic [CW-1:0]                        cnt;
    logic [SHARES-1:0][STATE_W-1:0]       wr;
    logic [SHARES-1:0][STATE_W-1:0]       rot;
    logic [SHARES-1:0][W-1:0]             tf;

    for (genvar s = 0; s < SHARES; s++) begin : g_share
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            affine_inv_nibble u_nib (
                .y   (wr[s][NIBBLE_W*l +: NIBBLE_W]),
                .cen (s == 0),
                .x   (tf[s][NIBBLE_W*l +: NIBBLE_W])
            );
        end
        // Transformed low slice re-enters at the top so N steps restore nibble order.
        if (LANES == 16) begin : g_full
            assign rot[s] = tf[s];
        end else begin : g_part
            assign rot[s] = {tf[s], wr[s][STATE_W-1:W]};
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = RUN;
            end
            RUN:  if (cnt == CW'(N - 1)) state_nx = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wr    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.in_valid) begin
                    wr  <= {bus.s3, bus.s2, bus.s1};
                    cnt <= '0;
                end
                RUN: begin
                    wr <= rot;
                    if (cnt != CW'(N - 1)) cnt <= cnt + CW'(1);
                end
`ifdef AFFINE_INV_ZEROIZE_EN
                DONE: if (bus.out_ready) wr <= '0;
`endif
                default: ;
            endcase
        end
    end

`ifdef AFFINE_INV_ZEROIZE_EN
    // Hide partially rotated shares; only the finished result is ever visible.
    assign bus.o1 = (state == DONE) ? wr[0] : '0;
    assign bus.o2 = (state == DONE) ? wr[1] : '0;
    assign bus.o3 = (state == DONE) ? wr[2] : '0;
`else
    assign bus.o1 = wr[0];
    assign bus.o2 = wr[1];
    assign bus.o3 = wr[2];
`endif
endmodule
